// File: rtl/traffic_light_monitor.sv
// ============================================================================
// Module      : traffic_light_monitor
// Description : Passive observer of a 3-group traffic-light controller. It
//               decodes the nine lamps into a phase, measures dwell time and
//               flags illegal patterns, illegal transitions and short phases.
//               Optional feature macro: MON_STATS_EN (adds ped_cnt output).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_monitor #(
    parameter int CNT_W   = 8,
    parameter int GRN_MIN = 10,
    parameter int YEL_MIN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             R1G,
    input  logic             R1Y,
    input  logic             R1R,
    input  logic             R2G,
    input  logic             R2Y,
    input  logic             R2R,
    input  logic             FG,
    input  logic             FY,
    input  logic             FR,
    input  logic             clr_err,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] dwell,
    output logic             phase_chg,
    output logic             err_pattern,
    output logic             err_seq,
    output logic             err_timing,
    output logic             err_any
`ifdef MON_STATS_EN
   ,output logic [7:0]       ped_cnt
`endif
);

    typedef enum logic [2:0] {
        PH_UNK = 3'd0,
        PH_R1G = 3'd1,
        PH_R1Y = 3'd2,
        PH_R2G = 3'd3,
        PH_R2Y = 3'd4,
        PH_FG  = 3'd5,
        PH_FY  = 3'd6,
        PH_ILL = 3'd7
    } phase_t;

    localparam logic [CNT_W-1:0] c_grn_min = CNT_W'(GRN_MIN);
    localparam logic [CNT_W-1:0] c_yel_min = CNT_W'(YEL_MIN);

    phase_t           r_phase;
    logic [CNT_W-1:0] r_dwell;
    logic             r_phase_chg;
    logic             r_dwell_ok;
    logic             r_err_pattern;
    logic             r_err_seq;
    logic             r_err_timing;

    phase_t           w_dec;
    logic [8:0]       w_lamps;
    logic             w_change;
    logic             w_old_valid;
    logic             w_new_valid;
    logic             w_sat;
    logic             w_legal;
    logic             w_is_green;
    logic             w_is_yellow;
    logic             w_set_pat;
    logic             w_set_seq;
    logic             w_set_tim;
    logic [CNT_W-1:0] w_dwell_d;
    logic             w_dwell_ok_d;

    assign w_lamps = {R1G, R1Y, R1R, R2G, R2Y, R2R, FG, FY, FR};

    always_comb begin
        w_dec        = PH_ILL;
        w_legal      = 1'b0;
        w_is_green   = 1'b0;
        w_is_yellow  = 1'b0;

        case (w_lamps)
            9'b100_001_001: w_dec = PH_R1G;
            9'b010_001_001: w_dec = PH_R1Y;
            9'b001_100_001: w_dec = PH_R2G;
            9'b001_010_001: w_dec = PH_R2Y;
            9'b001_001_100: w_dec = PH_FG;
            9'b001_001_010: w_dec = PH_FY;
            default:        w_dec = PH_ILL;
        endcase

        case (r_phase)
            PH_R1G: begin w_legal = (w_dec == PH_R1Y); w_is_green  = 1'b1; end
            PH_R1Y: begin w_legal = (w_dec == PH_R2G); w_is_yellow = 1'b1; end
            PH_R2G: begin w_legal = (w_dec == PH_R2Y); w_is_green  = 1'b1; end
            PH_R2Y: begin w_legal = (w_dec == PH_R1G) || (w_dec == PH_FG); w_is_yellow = 1'b1; end
            PH_FG:  begin w_legal = (w_dec == PH_FY);  w_is_green  = 1'b1; end
            PH_FY:  begin w_legal = (w_dec == PH_R1G); w_is_yellow = 1'b1; end
            default: w_legal = 1'b0;
        endcase

        w_change    = (w_dec != r_phase);
        w_old_valid = (r_phase != PH_UNK) && (r_phase != PH_ILL);
        w_new_valid = (w_dec != PH_ILL);
        w_sat       = &r_dwell;

        w_set_pat = w_change && (w_dec == PH_ILL);
        w_set_seq = w_change && w_old_valid && w_new_valid && !w_legal;
        // A saturated count is always long enough, whatever CNT_W is.
        w_set_tim = w_change && w_old_valid && r_dwell_ok && !w_sat &&
                    ((w_is_green  && (r_dwell < c_grn_min)) ||
                     (w_is_yellow && (r_dwell < c_yel_min)));

        if (w_change) begin
            w_dwell_d    = CNT_W'(1);
            w_dwell_ok_d = w_old_valid && w_new_valid;
        end else begin
            w_dwell_d    = w_sat ? r_dwell : r_dwell + CNT_W'(1);
            w_dwell_ok_d = r_dwell_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase       <= PH_UNK;
            r_dwell       <= '0;
            r_phase_chg   <= 1'b0;
            r_dwell_ok    <= 1'b0;
            r_err_pattern <= 1'b0;
            r_err_seq     <= 1'b0;
            r_err_timing  <= 1'b0;
        end else begin
            r_phase       <= w_dec;
            r_dwell       <= w_dwell_d;
            r_phase_chg   <= w_change;
            r_dwell_ok    <= w_dwell_ok_d;
            // A fresh error outranks a simultaneous clear.
            r_err_pattern <= (r_err_pattern & ~clr_err) | w_set_pat;
            r_err_seq     <= (r_err_seq     & ~clr_err) | w_set_seq;
            r_err_timing  <= (r_err_timing  & ~clr_err) | w_set_tim;
        end
    end

`ifdef MON_STATS_EN
    logic [7:0] r_ped_cnt;
    logic       w_ped_inc;

    assign w_ped_inc = w_change && (w_dec == PH_FG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ped_cnt <= 8'd0;
        end else if (w_ped_inc) begin
            if (r_ped_cnt != 8'hFF) begin
                r_ped_cnt <= r_ped_cnt + 8'd1;
            end
        end else if (clr_err) begin
            r_ped_cnt <= 8'd0;
        end
    end

    assign ped_cnt = r_ped_cnt;
`endif

    assign phase       = r_phase;
    assign dwell       = r_dwell;
    assign phase_chg   = r_phase_chg;
    assign err_pattern = r_err_pattern;
    assign err_seq     = r_err_seq;
    assign err_timing  = r_err_timing;
    assign err_any     = r_err_pattern | r_err_seq | r_err_timing;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
// ============================================================================
// Module      : tb_traffic_light_monitor
// Description : Bench for traffic_light_monitor: directed scenarios plus
//               random lamp sequences against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_monitor;

    localparam int c_grn = 10;
    localparam int c_yel = 3;
    localparam int c_dmax = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] lamps;
    logic       clr_err;
    logic [2:0] phase;
    logic [7:0] dwell;
    logic       phase_chg;
    logic       err_pattern;
    logic       err_seq;
    logic       err_timing;
    logic       err_any;
`ifdef MON_STATS_EN
    logic [7:0] ped_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int m_phase, m_dwell, m_ped;
    bit m_ok, m_chg, m_ep, m_es, m_et;

    always #5 clk = ~clk;

    traffic_light_monitor #(.CNT_W(8), .GRN_MIN(c_grn), .YEL_MIN(c_yel)) dut (
        .clk        (clk),
        .rst        (rst),
        .R1G        (lamps[8]),
        .R1Y        (lamps[7]),
        .R1R        (lamps[6]),
        .R2G        (lamps[5]),
        .R2Y        (lamps[4]),
        .R2R        (lamps[3]),
        .FG         (lamps[2]),
        .FY         (lamps[1]),
        .FR         (lamps[0]),
        .clr_err    (clr_err),
        .phase      (phase),
        .dwell      (dwell),
        .phase_chg  (phase_chg),
        .err_pattern(err_pattern),
        .err_seq    (err_seq),
        .err_timing (err_timing),
        .err_any    (err_any)
`ifdef MON_STATS_EN
       ,.ped_cnt    (ped_cnt)
`endif
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] pat(input int p);
        case (p)
            1: return 9'b100_001_001;
            2: return 9'b010_001_001;
            3: return 9'b001_100_001;
            4: return 9'b001_010_001;
            5: return 9'b001_001_100;
            6: return 9'b001_001_010;
            default: return 9'b000_000_000;
        endcase
    endfunction

    function automatic int decode(input logic [8:0] l);
        for (int p = 1; p <= 6; p++) if (l == pat(p)) return p;
        return 7;
    endfunction

    function automatic bit valid(input int p);
        return (p >= 1) && (p <= 6);
    endfunction

    function automatic bit legal(input int o, input int n);
        return (o == 1 && n == 2) || (o == 2 && n == 3) || (o == 3 && n == 4) ||
               (o == 4 && (n == 1 || n == 5)) || (o == 5 && n == 6) || (o == 6 && n == 1);
    endfunction

    function automatic int min_dwell(input int p);
        return (p == 1 || p == 3 || p == 5) ? c_grn : c_yel;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_dwell = 0; m_ped = 0;
        m_ok = 0; m_chg = 0; m_ep = 0; m_es = 0; m_et = 0;
    endtask

    task automatic model_edge(input logic [8:0] l, input bit c);
        int n;
        bit sp, ss, st, inc;
        n = decode(l);
        sp = 0; ss = 0; st = 0; inc = 0;
        if (n == m_phase) begin
            m_dwell = (m_dwell < c_dmax) ? m_dwell + 1 : c_dmax;
            m_chg   = 0;
        end else begin
            ss  = valid(m_phase) && valid(n) && !legal(m_phase, n);
            sp  = (n == 7);
            st  = valid(m_phase) && m_ok && (m_dwell < c_dmax) && (m_dwell < min_dwell(m_phase));
            inc = (n == 5);
            m_ok    = valid(m_phase) && valid(n);
            m_phase = n;
            m_dwell = 1;
            m_chg   = 1;
        end
        m_ep = (m_ep && !c) || sp;
        m_es = (m_es && !c) || ss;
        m_et = (m_et && !c) || st;
        if (inc) m_ped = (m_ped < 255) ? m_ped + 1 : 255;
        else if (c) m_ped = 0;
    endtask

    task automatic compare_all();
        check("phase", phase, m_phase);
        check("dwell", dwell, m_dwell);
        check("phase_chg", phase_chg, m_chg);
        check("err_pattern", err_pattern, m_ep);
        check("err_seq", err_seq, m_es);
        check("err_timing", err_timing, m_et);
        check("err_any", err_any, m_ep | m_es | m_et);
`ifdef MON_STATS_EN
        check("ped_cnt", ped_cnt, m_ped);
`endif
    endtask

    task automatic step(input logic [8:0] l, input bit c);
        lamps   = l;
        clr_err = c;
        @(posedge clk);
        model_edge(l, c);
        #1;
        compare_all();
    endtask

    task automatic hold(input int p, input int cycles);
        for (int i = 0; i < cycles; i++) step(pat(p), 1'b0);
    endtask

    task automatic run_loop();
        hold(1, 12); hold(2, 4); hold(3, 12); hold(4, 4); hold(5, 12); hold(6, 4);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int nxt, len, r;
        logic [8:0] l;

        lamps   = 9'd0;
        clr_err = 1'b0;
        model_reset();

        // Reset state, then all-dark lamps decode as illegal
        do_reset();
        check("rst_phase", phase, 0);
        check("rst_dwell", dwell, 0);
        check("rst_err_any", err_any, 0);
        step(9'd0, 1'b0);
        check("t1_phase", phase, 7);
        check("t1_err_pattern", err_pattern, 1);
        check("t1_err_any", err_any, 1);

        // Two legal loops, sticky flag cleared on entry
        step(pat(1), 1'b1);
        hold(1, 11); hold(2, 4); hold(3, 12); hold(4, 4); hold(5, 12); hold(6, 4);
        hold(1, 12);
        check("t2_dwell12", dwell, 12);
        hold(2, 4); hold(3, 12); hold(4, 4); hold(5, 12); hold(6, 4);
        step(pat(1), 1'b0);
        check("t2_phase_back", phase, 1);
        check("t2_chg", phase_chg, 1);
        check("t2_err_any", err_any, 0);

        // Sequence error right after reset: no timing error
        do_reset();
        hold(1, 5);
        step(pat(3), 1'b0);
        check("t3_err_seq", err_seq, 1);
        check("t3_err_timing", err_timing, 0);
        hold(3, 11);

        // Short yellow, then clear alone
        step(pat(4), 1'b1);
        hold(4, 3); hold(1, 12); hold(2, 2);
        step(pat(3), 1'b0);
        check("t4_err_timing", err_timing, 1);
        check("t4_err_seq", err_seq, 0);
        step(pat(3), 1'b1);
        check("t4_clr_any", err_any, 0);
        hold(3, 10);

        // Dwell saturation and asynchronous reset mid-phase
        hold(4, 4); hold(1, 300);
        check("t5_dwell_sat", dwell, 255);
        check("t5_err_any", err_any, 0);
        #2 rst = 1'b1;
        #1;
        check("t5_async_phase", phase, 0);
        check("t5_async_dwell", dwell, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        compare_all();

`ifdef MON_STATS_EN
        run_loop(); run_loop(); run_loop();
        check("t6_ped3", ped_cnt, 3);
        hold(1, 12); hold(2, 4); hold(3, 12); hold(4, 4);
        step(pat(5), 1'b1);
        check("t6_ped4", ped_cnt, 4);
        hold(5, 11); hold(6, 4);
`else
        run_loop();
`endif

        // Random phase sequences with occasional faults and clears
        for (int s = 0; s < 300; s++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                l   = 9'($urandom);
                len = $urandom_range(1, 4);
            end else begin
                if (r == 1 || !valid(m_phase)) nxt = $urandom_range(1, 6);
                else if (m_phase == 4) nxt = ($urandom_range(0, 1) == 0) ? 1 : 5;
                else nxt = (m_phase == 6) ? 1 : (m_phase == 2 ? 3 : m_phase + 1);
                l   = pat(nxt);
                len = (min_dwell(nxt) == c_grn) ? $urandom_range(7, 14) : $urandom_range(1, 5);
            end
            for (int i = 0; i < len; i++) step(l, $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
